// File: rtl/regfile_scoreboard_if.sv
// Register-file/scoreboard port bundle: two read ports, one write-back
// port, one issue port and the busy summary outputs.
interface regfile_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS) + 1;

    logic [AW-1:0]     rd_addr_a;
    logic [AW-1:0]     rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_busy_a;
    logic              rd_busy_b;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic [CW-1:0]     busy_count;
    logic              all_clear;

    // Pipeline side: drives addresses, write-back and issue; observes results.
    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_count, all_clear
    );

    // Register file side.
    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_count, all_clear
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard.
// r0 is hard-wired to zero and never busy. Reads are combinational with
// write-back bypass; a write-back releases its register's busy bit in the
// same cycle for readers, and an issue to the same register wins.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_scoreboard_if.slave   bus
);
    localparam int CW = $clog2(NUM_REGS) + 1;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CW-1:0]       busy_count_q, busy_count_d;

    logic wr_hit, issue_hit, set_new, clr_eff;
    logic byp_a, byp_b;

    // Next-state: data write, busy set/clear, and incremental busy count.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned (which would infer a latch).
        wr_hit       = bus.wr_en && (bus.wr_addr != '0);
        issue_hit    = bus.issue_en && (bus.issue_addr != '0);
        set_new      = issue_hit && !busy_q[bus.issue_addr];
        clr_eff      = wr_hit && busy_q[bus.wr_addr]
                       && !(issue_hit && (bus.issue_addr == bus.wr_addr));
        regs_d       = regs_q;
        busy_d       = busy_q;
        busy_count_d = busy_count_q;

        if (wr_hit) begin
            regs_d[bus.wr_addr] = bus.wr_data;
            busy_d[bus.wr_addr] = 1'b0;
        end
        // Issue is applied after the clear so a same-register issue wins.
        if (issue_hit) begin
            busy_d[bus.issue_addr] = 1'b1;
        end

        unique case ({set_new, clr_eff})
            2'b10:   busy_count_d = busy_count_q + CW'(1);
            2'b01:   busy_count_d = busy_count_q - CW'(1);
            default: busy_count_d = busy_count_q;
        endcase
    end

    // State registers; reset clears data, busy bits and count asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the register array is reset because r1..r31 must read 0
            // after reset; this forces flops rather than an inferred RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values.
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Combinational read ports with write-back bypass, forced quiet in reset.
    always_comb begin
        byp_a         = reset_n && wr_hit && (bus.wr_addr == bus.rd_addr_a);
        byp_b         = reset_n && wr_hit && (bus.wr_addr == bus.rd_addr_b);
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        bus.rd_busy_a = 1'b0;
        bus.rd_busy_b = 1'b0;
        if (reset_n) begin
            bus.rd_data_a = byp_a ? bus.wr_data : regs_q[bus.rd_addr_a];
            bus.rd_data_b = byp_b ? bus.wr_data : regs_q[bus.rd_addr_b];
            bus.rd_busy_a = busy_q[bus.rd_addr_a] && !byp_a;
            bus.rd_busy_b = busy_q[bus.rd_addr_b] && !byp_b;
        end
    end

    assign bus.busy_count = busy_count_q;
    assign bus.all_clear  = (busy_count_q == '0);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;
    logic clk;
    logic reset_n;
    int   pass_cnt;
    int   total_cnt;

    regfile_scoreboard_if #(.DATA_W(32), .NUM_REGS(32)) bus ();

    regfile_scoreboard #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en    = 1'b0;
        bus.issue_en = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n        = 1'b0;
        bus.rd_addr_a  = '0;
        bus.rd_addr_b  = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        #2;

        // Reset state: every register reads 0 and idle on both ports.
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr_a = 5'(i);
            bus.rd_addr_b = 5'(31 - i);
            #1;
            check($sformatf("rst_data_a[%0d]", i), bus.rd_data_a, 32'h0);
            check($sformatf("rst_data_b[%0d]", 31 - i), bus.rd_data_b, 32'h0);
            check($sformatf("rst_busy_a[%0d]", i), 32'(bus.rd_busy_a), 32'h0);
            check($sformatf("rst_busy_b[%0d]", 31 - i), 32'(bus.rd_busy_b), 32'h0);
        end
        check("rst_count", 32'(bus.busy_count), 32'd0);
        check("rst_all_clear", 32'(bus.all_clear), 32'd1);

        // Writes and issues are ignored in reset, and bypass is disabled.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h1234_5678;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd5; bus.rd_addr_a = 5'd5;
        #1;
        check("rst_no_bypass", bus.rd_data_a, 32'h0);
        check("rst_no_busy", 32'(bus.rd_busy_a), 32'h0);
        cycle();
        check("rst_ignore_write", bus.rd_data_a, 32'h0);
        check("rst_ignore_issue", 32'(bus.busy_count), 32'd0);
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // Write r5 with same-cycle bypass on both ports, then plain read.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEAD_BEEF;
        bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd5;
        #1;
        check("bypass_a", bus.rd_data_a, 32'hDEAD_BEEF);
        check("bypass_b", bus.rd_data_b, 32'hDEAD_BEEF);
        cycle();
        idle_inputs();
        #1;
        check("r5_after_write", bus.rd_data_a, 32'hDEAD_BEEF);

        // r0 ignores writes and issues.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd0; bus.rd_addr_a = 5'd0;
        #1;
        check("r0_no_bypass", bus.rd_data_a, 32'h0);
        cycle();
        idle_inputs();
        #1;
        check("r0_data", bus.rd_data_a, 32'h0);
        check("r0_busy", 32'(bus.rd_busy_a), 32'h0);
        check("r0_count", 32'(bus.busy_count), 32'd0);
        check("r0_all_clear", 32'(bus.all_clear), 32'd1);

        // Issue r3 then r7; write-back r3 releases readers in the same cycle.
        bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
        cycle();
        bus.issue_addr = 5'd7;
        cycle();
        idle_inputs();
        bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd7;
        #1;
        check("count_two", 32'(bus.busy_count), 32'd2);
        check("not_clear", 32'(bus.all_clear), 32'd0);
        check("r3_busy", 32'(bus.rd_busy_a), 32'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h0000_0033;
        #1;
        check("r3_release", 32'(bus.rd_busy_a), 32'd0);
        check("r3_bypass", bus.rd_data_a, 32'h0000_0033);
        check("r7_still_busy", 32'(bus.rd_busy_b), 32'd1);
        cycle();
        idle_inputs();
        #1;
        check("count_one", 32'(bus.busy_count), 32'd1);
        check("r3_clear", 32'(bus.rd_busy_a), 32'd0);
        check("r3_data", bus.rd_data_a, 32'h0000_0033);

        // Busy r9, then write-back and re-issue r9 together: issue wins.
        bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
        cycle();
        check("count_r9", 32'(bus.busy_count), 32'd2);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0000_0099;
        cycle();
        idle_inputs();
        bus.rd_addr_a = 5'd9;
        #1;
        check("r9_issue_wins", 32'(bus.rd_busy_a), 32'd1);
        check("count_same_reg", 32'(bus.busy_count), 32'd2);

        // Issue r4 while r9 writes back: both take effect.
        bus.issue_en = 1'b1; bus.issue_addr = 5'd4;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0000_0909;
        cycle();
        idle_inputs();
        bus.rd_addr_a = 5'd4; bus.rd_addr_b = 5'd9;
        #1;
        check("count_diff_reg", 32'(bus.busy_count), 32'd2);
        check("r4_busy", 32'(bus.rd_busy_a), 32'd1);
        check("r9_clear", 32'(bus.rd_busy_b), 32'd0);
        check("r9_data", bus.rd_data_b, 32'h0000_0909);

        // Write to a non-busy register: data updates, busy untouched.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 32'hA5A5_A5A5;
        cycle();
        idle_inputs();
        bus.rd_addr_a = 5'd31; bus.rd_addr_b = 5'd31;
        #1;
        check("r31_data_a", bus.rd_data_a, 32'hA5A5_A5A5);
        check("r31_data_b", bus.rd_data_b, 32'hA5A5_A5A5);
        check("r31_not_busy", 32'(bus.rd_busy_a), 32'd0);
        check("count_nonbusy_wr", 32'(bus.busy_count), 32'd2);

        // Re-issue busy r7: count must not change.
        bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
        cycle();
        idle_inputs();
        #1;
        check("count_reissue", 32'(bus.busy_count), 32'd2);

        // Fill r1..r31 busy (r4 and r7 already busy).
        bus.issue_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.issue_addr = 5'(i);
            cycle();
        end
        idle_inputs();
        bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd31;
        #1;
        check("count_full", 32'(bus.busy_count), 32'd31);
        check("full_not_clear", 32'(bus.all_clear), 32'd0);
        check("full_r0_busy", 32'(bus.rd_busy_a), 32'd0);
        check("full_r31_busy", 32'(bus.rd_busy_b), 32'd1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        bus.rd_addr_a = 5'd5;
        reset_n = 1'b0;
        #1;
        check("async_count", 32'(bus.busy_count), 32'd0);
        check("async_all_clear", 32'(bus.all_clear), 32'd1);
        check("async_data", bus.rd_data_a, 32'h0);
        check("async_busy", 32'(bus.rd_busy_b), 32'd0);

        // First edge after reset release is an ordinary cycle.
        @(negedge clk);
        reset_n = 1'b1;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd2;
        cycle();
        idle_inputs();
        bus.rd_addr_a = 5'd2;
        #1;
        check("post_rst_count", 32'(bus.busy_count), 32'd1);
        check("post_rst_busy", 32'(bus.rd_busy_a), 32'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h0000_0002;
        cycle();
        idle_inputs();
        #1;
        check("post_rst_drain", 32'(bus.busy_count), 32'd0);
        check("post_rst_clear", 32'(bus.all_clear), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
